// File: rtl/entrada_serial_4bits_pkg.sv
// Shared types and default constants for the serial switch input stage.
package entrada_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } estado_t;

    localparam int NBITS_REG_DFLT       = 4;
    localparam int DEBOUNCE_CYCLES_DFLT = 3;

endpackage

// File: rtl/entrada_serial_4bits_filtro.sv
// Strobe conditioner: 2-flop synchronizer, stability-count debounce and
// rising-edge detect of the debounced level.
module filtro_debounce
    import entrada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
    input  logic clk_2,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_db;
    logic       w_s;
    logic       w_diff;
    logic       w_hit;

    assign w_s    = r_sync[1];
    assign w_diff = (w_s != r_db);
    // The edge that would bring the counter to DEBOUNCE_CYCLES accepts the level.
    assign w_hit  = w_diff && (r_cnt == 4'(DEBOUNCE_CYCLES - 1));

    // Bring the raw switch into the clk_2 domain.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], din};
    end

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_db  <= 1'b0;
        end else if (!w_diff) begin
            r_cnt <= 4'd0;
        end else if (w_hit) begin
            r_cnt <= 4'd0;
            r_db  <= w_s;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign dout = r_db;
    // Combinational: true in the cycle whose closing edge takes the level 0->1.
    assign rise = w_hit && w_s;

endmodule

// File: rtl/entrada_serial_4bits.sv
// Serial word assembler: one data bit per debounced strobe rise, MSB first,
// with a one-cycle valid pulse when a full word lands on data_out.
module entrada_serial_4bits
    import entrada_pkg::*;
#(
    parameter int NBITS_REG       = NBITS_REG_DFLT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter int CNT_W           = $clog2(NBITS_REG + 1)
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 strobe_in,
    input  logic                 clear,
    output logic [NBITS_REG-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_W-1:0]     bit_count,
    output logic                 busy
);

    logic [1:0]           r_ser_sync;
    logic                 w_serial_s;
    logic                 w_strobe_db;
    logic                 w_shift_evt;

    estado_t              r_estado, w_nxt_estado;
    logic [NBITS_REG-1:0] r_shift, w_nxt_shift;
    logic [NBITS_REG-1:0] r_data, w_nxt_data;
    logic [CNT_W-1:0]     r_cnt, w_nxt_cnt;
    logic                 r_valid, w_nxt_valid;
    logic [NBITS_REG-1:0] w_shifted;
    logic [NBITS_REG-1:0] w_first;

    filtro_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro_strobe (
        .clk_2 (clk_2),
        .reset (reset),
        .din   (strobe_in),
        .dout  (w_strobe_db),
        .rise  (w_shift_evt)
    );

    // Data switch only needs metastability protection; the strobe qualifies it.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) r_ser_sync <= 2'b00;
        else        r_ser_sync <= {r_ser_sync[0], serial_in};
    end
    assign w_serial_s = r_ser_sync[1];

    // Shift expressions written so that a 1-bit word also elaborates.
    assign w_shifted = (r_shift << 1) | NBITS_REG'(w_serial_s);
    assign w_first   = NBITS_REG'(w_serial_s);

    // State and datapath registers.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_estado <= IDLE;
            r_shift  <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_estado <= w_nxt_estado;
            r_shift  <= w_nxt_shift;
            r_data   <= w_nxt_data;
            r_cnt    <= w_nxt_cnt;
            r_valid  <= w_nxt_valid;
        end
    end

    // Next-state: collect bits, complete the word, then apply clear last so it wins.
    always_comb begin
        w_nxt_estado = r_estado;
        w_nxt_shift  = r_shift;
        w_nxt_data   = r_data;
        w_nxt_cnt    = r_cnt;
        w_nxt_valid  = 1'b0;
        case (r_estado)
            // DONE behaves like IDLE so a rise during the pulse starts the next word.
            IDLE, DONE: begin
                w_nxt_estado = IDLE;
                if (w_shift_evt) begin
                    w_nxt_shift = w_first;
                    if (NBITS_REG == 1) begin
                        w_nxt_data   = w_first;
                        w_nxt_cnt    = '0;
                        w_nxt_estado = DONE;
                        w_nxt_valid  = 1'b1;
                    end else begin
                        w_nxt_cnt    = CNT_W'(1);
                        w_nxt_estado = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (w_shift_evt) begin
                    w_nxt_shift = w_shifted;
                    if (r_cnt == CNT_W'(NBITS_REG - 1)) begin
                        w_nxt_data   = w_shifted;
                        w_nxt_cnt    = '0;
                        w_nxt_estado = DONE;
                        w_nxt_valid  = 1'b1;
                    end else begin
                        w_nxt_cnt    = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_nxt_estado = IDLE;
        endcase
        if (clear) begin
            w_nxt_shift  = '0;
            w_nxt_cnt    = '0;
            w_nxt_data   = r_data;
            w_nxt_estado = IDLE;
            w_nxt_valid  = 1'b0;
        end
    end

    // A rise can only be reported while the accepted strobe level is still low.
    assert property (@(posedge clk_2) disable iff (!reset) w_shift_evt |-> !w_strobe_db);

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign bit_count = r_cnt;
    assign busy      = (r_cnt != '0);

endmodule

// File: doc/entrada_serial_4bits.md
Name: entrada_serial_4bits

Overview:
Upstream input stage for the 4-bit register. It converts two slide switches into clean serial words:
- SWI[1] is the data bit; SWI[3] is the shift strobe.
- Both switches are synchronized to clk_2. The strobe is debounced.
- One data bit is shifted in on each debounced strobe rising edge, MSB first.
- After NBITS_REG bits, the block presents a full parallel word plus a one-cycle valid pulse. The register stage loads this word in place of its raw input_serial/input_paralelo path.

Parameters:
- NBITS_REG, 4: word width; also the number of strobes per word.
- DEBOUNCE_CYCLES, 3: consecutive stable clk_2 samples required to accept a strobe level change; legal range 1..15.
- CNT_W, $clog2(NBITS_REG+1): width of bit_count.

Ports:
- clk_2, input, 1: system clock, all state on its rising edge.
- reset, input, 1: asynchronous, active-low; 0 clears all state immediately, release is synchronous to clk_2.
- serial_in, input, 1: raw data switch, asynchronous.
- strobe_in, input, 1: raw shift-strobe switch, asynchronous.
- clear, input, 1: synchronous abort of the partial word, active-high.
- data_out, output, NBITS_REG: last completed word.
- valid_out, output, 1: one-cycle pulse when data_out updates.
- bit_count, output, CNT_W: bits received in the current word, 0..NBITS_REG-1.
- busy, output, 1: 1 while a partial word is held (bit_count != 0).

Behaviour:
Reset (reset=0), asynchronous:
- data_out=0, valid_out=0, bit_count=0, busy=0.
- shift register=0; both synchronizer chains=0; strobe_db=0; debounce counter=0; FSM=IDLE.

Synchronization and debounce:
- serial_in and strobe_in each pass through a 2-flop synchronizer (serial_s, strobe_s).
- Debounce counter:
  - Resets to 0 on any cycle where strobe_s == strobe_db.
  - Increments on each cycle where strobe_s != strobe_db.
  - On the edge where it would reach DEBOUNCE_CYCLES, strobe_db takes strobe_s and the counter returns to 0.
- Glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- shift_evt is combinational and true in the cycle whose closing edge changes strobe_db 0->1.
- Falling edges never shift.
- Latency: strobe_in rises and is stable before edge t0, so strobe_s=1 after edge t0+1. The shift occurs at edge t0+1+DEBOUNCE_CYCLES.

FSM (states IDLE, COLLECT, DONE), transitions on clk_2:
- IDLE:
  - shift_evt: shift in serial_s, bit_count=1, go to COLLECT.
  - If NBITS_REG==1: go directly to DONE.
- COLLECT:
  - shift_evt: shift_reg <= {shift_reg[NBITS_REG-2:0], serial_s}; bit_count++.
  - When that shift makes the bit count reach NBITS_REG: data_out <= the shifted value, bit_count=0, go to DONE.
- DONE:
  - valid_out=1 for exactly this one cycle.
  - Next state is IDLE, or COLLECT with bit_count=1 if shift_evt is also true in this cycle. The shift is not lost.

Output and boundary rules:
- valid_out is registered. It is 1 only in DONE, never for two consecutive cycles.
- data_out holds its value until the next word completes. clear does not alter it.
- clear=1 in any state:
  - shift_reg=0, bit_count=0, next state IDLE.
  - clear wins over a simultaneous shift_evt.
  - If clear is asserted while in DONE, valid_out still pulses in that cycle.
- bit_count never equals NBITS_REG at the output; it wraps to 0 on completion.
- serial_s is sampled in the same cycle as shift_evt. The user must set the data switch before toggling the strobe.
- Reset asserted mid-word discards the partial word and data_out.

Decomposition:
- Package entrada_pkg:
  - typedef enum logic [1:0] {IDLE, COLLECT, DONE} estado_t.
  - Default constants NBITS_REG and DEBOUNCE_CYCLES.
- Sub-module filtro_debounce(clk_2, reset, din, dout, rise), with parameter DEBOUNCE_CYCLES. It contains the synchronizer, the counter and rising-edge detection, and is instantiated once for the strobe.
- The data path uses only a plain 2-flop synchronizer inside the top block.

Test Plan:
1. Reset=0 for 2 cycles with random switches, then release. Required: data_out=0, valid_out=0, bit_count=0, busy=0; nothing changes until a strobe arrives.
2. Four clean strobes (each held high and then low for 8 cycles) with serial_in = 1,0,1,1 set before each strobe.
   - bit_count steps 1,2,3, then returns to 0.
   - data_out=4'b1011 with valid_out high for exactly 1 cycle.
   - First shift at edge t0+1+3 after the strobe rises.
3. Strobe glitch: high for 2 cycles, then low, with DEBOUNCE_CYCLES=3. Required: no shift, bit_count stays 0. Then a 3-cycle-stable high gives exactly one shift.
4. After 2 bits (1,1), assert clear for 1 cycle, then send 4 bits 0,1,0,0. Required: data_out=4'b0100, never containing the aborted bits.
5. Complete word 4'b1111, then time the next debounced rise to fall in the DONE cycle. Required: valid_out pulses once and bit_count=1 the following cycle.
6. Assert reset=0 asynchronously mid-cycle after 3 bits. Required: all outputs go to 0 immediately, without waiting for a clock edge. A subsequent 4-bit word 0,0,1,0 yields data_out=4'b0010.
